// File: rtl/bridge_rx_pkg.sv
// Shared definitions for the UART-to-bus bridge: FSM states, ASCII codes and hex decode.
package bridge_rx_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_TERM = 2'd3
  } state_e;

  localparam logic [BYTE_W-1:0] ASCII_R  = 8'h52;
  localparam logic [BYTE_W-1:0] ASCII_W  = 8'h57;
  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  typedef struct packed {
    logic             valid;
    logic [NIB_W-1:0] nib;
  } hex_t;

  // Decode one ASCII hex character (0-9, A-F, a-f) into a nibble.
  function automatic hex_t hex_decode(input logic [BYTE_W-1:0] c);
    hex_t r;
    r.valid = 1'b1;
    r.nib   = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r.nib = NIB_W'(c - 8'h30);
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r.nib = NIB_W'(c - 8'h37);
    end else if (c >= 8'h61 && c <= 8'h66) begin
      r.nib = NIB_W'(c - 8'h57);
    end else begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bridge_rx.sv
// ASCII command parser: turns "Raaaa<term>" / "Waaaadddd<term>" byte streams into bus requests.
module bridge_rx
  import bridge_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              valid_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              rw_o,
  output logic              valid_o
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] ash_q, ash_d;
  logic [DATA_W-1:0] dsh_q, dsh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rwo_q, rwo_d;
  logic              valid_q, valid_d;

  hex_t hex_c;
  logic is_cmd_c;
  logic is_term_c;

  assign hex_c     = hex_decode(data_i);
  assign is_cmd_c  = (data_i == ASCII_R) || (data_i == ASCII_W);
  assign is_term_c = (data_i == ASCII_CR) || (data_i == ASCII_LF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      ash_q   <= '0;
      dsh_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rwo_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      ash_q   <= ash_d;
      dsh_q   <= dsh_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rwo_q   <= rwo_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: a command letter restarts from any state; anything unexpected drops to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    ash_d   = ash_q;
    dsh_d   = dsh_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rwo_d   = rwo_q;
    valid_d = 1'b0;

    if (valid_i) begin
      if (is_cmd_c) begin
        state_d = ST_ADDR;
        rw_d    = (data_i == ASCII_W);
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_ADDR: begin
            if (hex_c.valid) begin
              ash_d = {ash_q[ADDR_W-NIB_W-1:0], hex_c.nib};
              cnt_d = cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                state_d = rw_q ? ST_DATA : ST_TERM;
              end
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end
          ST_DATA: begin
            if (hex_c.valid) begin
              dsh_d = {dsh_q[DATA_W-NIB_W-1:0], hex_c.nib};
              cnt_d = cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                state_d = ST_TERM;
              end
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end
          ST_TERM: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (is_term_c) begin
              valid_d = 1'b1;
              addr_d  = ash_q;
              wdata_d = rw_q ? dsh_q : '0;
              rwo_d   = rw_q;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;
  assign rw_o    = rwo_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Bench for bridge_rx: directed message scenarios plus randomized byte streams against a message-level model.
module tb_bridge_rx;

  logic        clk;
  logic        rst;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] addr_o;
  logic [15:0] wdata_o;
  logic        rw_o;
  logic        valid_o;

  bridge_rx dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .addr_o  (addr_o),
    .wdata_o (wdata_o),
    .rw_o    (rw_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: the characters of the message in progress (empty means idle).
  byte unsigned msg[$];
  logic        m_valid = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_wdata = '0;
  logic        m_rw    = 1'b0;

  int          pulses = 0;
  logic [15:0] cap_addr  = '0;
  logic [15:0] cap_wdata = '0;
  logic        cap_rw    = 1'b0;

  function automatic int hexval(input byte unsigned c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  function automatic logic [15:0] fold4(input int first);
    logic [15:0] v = '0;
    for (int i = 0; i < 4; i++) v = v * 16 + 16'(hexval(msg[first + i]));
    return v;
  endfunction

  task automatic model_byte(input byte unsigned b);
    int limit;
    if (b == "R" || b == "W") begin
      msg.delete();
      msg.push_back(b);
    end else if (msg.size() == 0) begin
      // idle: everything else is ignored
    end else if (b == 8'h0D || b == 8'h0A) begin
      if ((msg[0] == "R" && msg.size() == 5) || (msg[0] == "W" && msg.size() == 9)) begin
        m_valid = 1'b1;
        m_rw    = (msg[0] == "W");
        m_addr  = fold4(1);
        m_wdata = m_rw ? fold4(5) : 16'h0000;
      end
      msg.delete();
    end else begin
      limit = (msg[0] == "W") ? 9 : 5;
      if (hexval(b) >= 0 && msg.size() < limit) msg.push_back(b);
      else msg.delete();
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      msg.delete();
      m_valid = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_rw    = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (valid_i) model_byte(data_i);
    end
  end

  // Every cycle: outputs must match the model exactly, including held values.
  always @(negedge clk) begin
    n_cmp++;
    if (valid_o !== m_valid || addr_o !== m_addr || wdata_o !== m_wdata || rw_o !== m_rw) begin
      n_err++;
      $display("FAIL cycle_cmp t=%0t: got v=%b a=%h d=%h rw=%b, need v=%b a=%h d=%h rw=%b",
               $time, valid_o, addr_o, wdata_o, rw_o, m_valid, m_addr, m_wdata, m_rw);
    end
    if (valid_o === 1'b1) begin
      pulses++;
      cap_addr  = addr_o;
      cap_wdata = wdata_o;
      cap_rw    = rw_o;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input byte unsigned b, input int gap);
    @(negedge clk);
    data_i  = b;
    valid_i = 1'b1;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      valid_i = 1'b0;
      data_i  = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  // '|' stands for CR and '~' for LF.
  task automatic send_str(input string s, input int gap);
    byte unsigned c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "|") c = 8'h0D;
      else if (c == "~") c = 8'h0A;
      send_byte(c, gap);
    end
    idle(1);
  endtask

  function automatic byte unsigned hexch(input int v, input bit lower);
    if (v < 10) return 8'(48 + v);
    return lower ? 8'(87 + v) : 8'(55 + v);
  endfunction

  task automatic rand_msg();
    byte unsigned seq[$];
    bit is_w;
    int ndig;
    is_w = 1'($urandom);
    seq.push_back(is_w ? 8'h57 : 8'h52);
    ndig = is_w ? 8 : 4;
    for (int i = 0; i < ndig; i++) seq.push_back(hexch($urandom_range(15), 1'($urandom)));
    case ($urandom_range(2))
      0: seq.push_back(8'h0D);
      1: seq.push_back(8'h0A);
      default: begin seq.push_back(8'h0D); seq.push_back(8'h0A); end
    endcase
    if ($urandom_range(3) == 0) begin
      int pos = $urandom_range(seq.size() - 1);
      case ($urandom_range(5))
        0: seq[pos] = 8'h52;
        1: seq[pos] = 8'h57;
        2: seq[pos] = 8'h0D;
        3: seq[pos] = "G";
        4: seq.insert(pos, hexch($urandom_range(15), 1'b0));
        default: seq[pos] = 8'($urandom);
      endcase
    end
    foreach (seq[i]) send_byte(seq[i], ($urandom_range(3) == 0) ? $urandom_range(1, 2) : 0);
  endtask

  int p0;

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    idle(3);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_addr",  int'(addr_o), 0);
    chk("reset_wdata", int'(wdata_o), 0);
    chk("reset_rw",    int'(rw_o), 0);
    rst = 1'b0;
    idle(2);

    p0 = pulses; send_str("R0012|~", 0); idle(3);
    chk("rd_pulses", pulses - p0, 1);
    chk("rd_addr", int'(cap_addr), 16'h0012);
    chk("rd_rw", int'(cap_rw), 0);
    chk("rd_wdata", int'(cap_wdata), 0);

    p0 = pulses; send_str("W00A5beef~", 1); idle(3);
    chk("wr_pulses", pulses - p0, 1);
    chk("wr_addr", int'(cap_addr), 16'h00A5);
    chk("wr_wdata", int'(cap_wdata), 16'hBEEF);
    chk("wr_rw", int'(cap_rw), 1);

    p0 = pulses; send_str("R00G1|", 0); idle(3);
    chk("badhex_pulses", pulses - p0, 0);
    send_str("R0003|", 0); idle(3);
    chk("after_badhex_pulses", pulses - p0, 1);
    chk("after_badhex_addr", int'(cap_addr), 16'h0003);

    p0 = pulses; send_str("W0001R0007|", 0); idle(3);
    chk("restart_pulses", pulses - p0, 1);
    chk("restart_addr", int'(cap_addr), 16'h0007);
    chk("restart_rw", int'(cap_rw), 0);

    p0 = pulses; send_str("R12345|", 0); idle(3);
    chk("extra_digit_pulses", pulses - p0, 0);
    send_str("R0004|", 0); idle(3);
    chk("after_extra_pulses", pulses - p0, 1);
    chk("after_extra_addr", int'(cap_addr), 16'h0004);

    p0 = pulses; send_str("W00010", 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", int'(valid_o), 0);
    chk("rst_mid_addr",  int'(addr_o), 0);
    chk("rst_mid_wdata", int'(wdata_o), 0);
    chk("rst_mid_rw",    int'(rw_o), 0);
    @(negedge clk); rst = 1'b0;
    idle(2);
    chk("rst_mid_pulses", pulses - p0, 0);
    send_str("R0002|", 0); idle(3);
    chk("after_rst_pulses", pulses - p0, 1);
    chk("after_rst_addr", int'(cap_addr), 16'h0002);

    for (int m = 0; m < 400; m++) begin
      rand_msg();
      if ($urandom_range(7) == 0) idle($urandom_range(1, 3));
    end
    idle(4);
    chk("random_saw_requests", int'(pulses > p0 + 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bridge_rx.md
BRIDGE_RX -- requirements
Module: bridge_rx

Interface
REQ-001 The module SHALL have no parameters; address and data widths are fixed at 16 bits to match the register/memory bus chain.
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 data_i  input  8  received ASCII byte from the UART receiver.
REQ-005 valid_i  input  1  one-cycle strobe; data_i holds a byte on this cycle.
REQ-006 addr_o  output  16  bus address to the first core in the chain.
REQ-007 wdata_o  output  16  bus write data.
REQ-008 rw_o  output  1  1 = write, 0 = read.
REQ-009 valid_o  output  1  one-cycle bus request strobe.

Function
REQ-010 The module SHALL parse read messages 'R' + 4 hex digits + terminator into a read request on addr_o.
REQ-011 The module SHALL parse write messages 'W' + 4 hex address digits + 4 hex data digits + terminator into a write request on addr_o and wdata_o.
REQ-012 Hex digits SHALL be 0-9, A-F and a-f; the most significant nibble arrives first.
REQ-013 The terminator SHALL be CR (0x0D) or LF (0x0A); a CR/LF or LF received in IDLE SHALL be ignored, so "\r\n" yields exactly one request.
REQ-014 The FSM SHALL have states IDLE, ADDR, DATA and TERM, plus a 2-bit nibble counter and a latched rw flag.
REQ-015 IDLE: 'R' SHALL go to ADDR with rw=0; 'W' SHALL go to ADDR with rw=1; any other byte SHALL keep IDLE.
REQ-016 ADDR: each hex digit SHALL shift into the address register; after the 4th digit the FSM SHALL go to DATA if rw=1, else to TERM.
REQ-017 DATA: each hex digit SHALL shift into the data register; after the 4th digit the FSM SHALL go to TERM.
REQ-018 TERM: a terminator SHALL issue the request and return to IDLE.
REQ-019 In ADDR, DATA or TERM, 'R' or 'W' SHALL abort the current message and start a new one as in IDLE.
REQ-020 In ADDR, DATA or TERM, any other unexpected byte (non-hex, early terminator, or a 5th digit in TERM) SHALL abort to IDLE with no request issued.
REQ-021 valid_o SHALL be registered and assert for exactly one cycle, the cycle after the valid_i cycle carrying the terminator.
REQ-022 addr_o, wdata_o and rw_o SHALL be valid while valid_o=1 and SHALL hold their last issued values otherwise.
REQ-023 For a read request, wdata_o SHALL be driven as 0.
REQ-024 Bytes on cycles with valid_i=0 SHALL be ignored; there is no backpressure, and back-to-back valid_i cycles SHALL be accepted.

Reset
REQ-025 While rst=1, the FSM SHALL go to IDLE and the nibble counter, rw flag, addr_o, wdata_o, rw_o and valid_o SHALL all be cleared to 0.
REQ-026 A reset asserted mid-message SHALL discard the partial message; no valid_o SHALL assert for it.

Structure
REQ-027 A shared bridge package SHALL hold the state enum, the ASCII constants ('R', 'W', CR, LF) and a hex-to-nibble decode function returning a {valid, nibble} pair.
REQ-028 No sub-module is required; the module SHALL be a single FSM with shift registers.

Verification
REQ-029 Send "R0012\r\n" -> a single one-cycle valid_o with addr_o=0x0012, rw_o=0 and wdata_o=0x0000.
REQ-030 Send "W00A5beef\n" -> a single valid_o with addr_o=0x00A5, wdata_o=0xBEEF and rw_o=1.
REQ-031 Send "R00G1\r" then "R0003\r" -> no request for the first message, then a request with addr_o=0x0003.
REQ-032 Send "W0001R0007\r" -> one read request with addr_o=0x0007; no write is issued.
REQ-033 Send "R12345\r" -> no request; then send "R0004\r" -> a request with addr_o=0x0004.
REQ-034 Pulse rst after "W00010" -> no valid_o; then send "R0002\r" -> a request with addr_o=0x0002, with all outputs 0 while rst is high.
